// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and constants for the shared-register arbiter: FSM encoding, default sizes and
// the fixed index width used for owner/pointer/select values.
package shared_reg_arbiter_pkg;

  localparam int unsigned DefaultN = 4;
  localparam int unsigned DefaultW = 8;
  // Fixed at 3 bits so the owner port width stays constant across N = 2..8.
  localparam int unsigned IdxW     = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StClear = 2'd2
  } state_e;

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter. The arbiter takes the slave modport, and
// requesters take the master modport.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = DefaultW
) ();

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic           clr_req;
  logic [N-1:0]   gnt;
  logic           clr_done;
  logic [W-1:0]   q;
  logic [IdxW-1:0] owner;
  logic           busy;

  modport master (
    output req, wdata, clr_req,
    input  gnt, clr_done, q, owner, busy
  );

  modport slave (
    input  req, wdata, clr_req,
    output gnt, clr_done, q, owner, busy
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker (rr_pick): the first set request at or above ptr wins,
// and the search wraps from N-1 back to 0.
module shared_reg_arbiter_rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] winner_o,
  output logic            any_o
);

  logic [7:0]      req_pad;
  logic [IdxW-1:0] idx;

  // Walk the offsets from farthest to nearest, so the nearest set bit is the last one written.
  always_comb begin
    req_pad  = 8'(req_i);
    idx      = '0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = IdxW'((int'(ptr_i) + i) % int'(N));
      if (req_pad[idx]) begin
        winner_o = idx;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that serialises N requesters' writes and clear requests to one shared
// W-bit register. Each write or clear takes an IDLE -> GRANT/CLEAR -> IDLE pass.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = DefaultW
) (
  input logic                 clk,
  input logic                 rst,
  shared_reg_arbiter_if.slave bus
);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [W-1:0]    q_q, q_d;

  logic [IdxW-1:0] winner;
  logic            any;
  logic [W-1:0]    wdata_arr [8];

  shared_reg_arbiter_rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any)
  );

  // Lanes above N are tied to zero so that a 3-bit select always lands on a defined entry.
  for (genvar g = 0; g < 8; g++) begin : gen_lane
    if (g < N) begin : gen_used
      assign wdata_arr[g] = bus.wdata[g*W +: W];
    end else begin : gen_unused
      assign wdata_arr[g] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    owner_d = owner_q;
    q_d     = q_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_req) begin
          state_d = StClear;
        end else if (any) begin
          sel_d   = winner;
          state_d = StGrant;
        end
      end
      StGrant: begin
        q_d     = wdata_arr[sel_q];
        owner_d = sel_q;
        ptr_d   = (sel_q == IdxW'(N - 1)) ? '0 : sel_q + IdxW'(1);
        state_d = StIdle;
      end
      StClear: begin
        q_d     = '0;
        owner_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      owner_q <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      owner_q <= owner_d;
      q_q     <= q_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : gen_gnt
    assign bus.gnt[g] = (state_q == StGrant) && (sel_q == IdxW'(g));
  end

  assign bus.clr_done = (state_q == StClear);
  assign bus.busy     = (state_q != StIdle);
  assign bus.q        = q_q;
  assign bus.owner    = owner_q;

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, meaning the shared register width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  meaning synchronous active-high reset, sampled on posedge clk.
REQ-005 SHALL have port req  input  N  meaning per-requester write request, level-held until granted.
REQ-006 SHALL have port wdata  input  N*W  meaning requester i's data in bits [i*W +: W].
REQ-007 SHALL have port clr_req  input  1  meaning request to synchronously clear the shared register.
REQ-008 SHALL have port gnt  output  N  meaning one-hot grant, high for exactly one cycle per accepted write.
REQ-009 SHALL have port clr_done  output  1  meaning one-cycle pulse in the cycle a clear is executed.
REQ-010 SHALL have port q  output  W  meaning the shared register contents.
REQ-011 SHALL have port owner  output  3  meaning index of the last requester written; 0 after reset or clear.
REQ-012 SHALL have port busy  output  1  meaning high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, GRANT and CLEAR.
REQ-014 In IDLE with clr_req=1, SHALL go to CLEAR next edge, regardless of req.
REQ-015 In IDLE with clr_req=0 and req!=0, SHALL latch the round-robin winner into sel and go to GRANT.
REQ-016 In IDLE with clr_req=0 and req=0, SHALL stay in IDLE with all outputs held.
REQ-017 Round-robin SHALL search from index ptr upward, wrapping from N-1 to 0; the first set req bit wins.
REQ-018 In GRANT, gnt[sel] SHALL be 1 and all other gnt bits 0; at the closing edge q<=wdata[sel], owner<=sel, ptr<=(sel+1) mod N, state<=IDLE.
REQ-019 In CLEAR, clr_done SHALL be 1; at the closing edge q<=0, owner<=0, state<=IDLE; ptr SHALL be unchanged.
REQ-020 Latency: req sampled at edge k, gnt high in cycle k+1, new q visible after edge k+1.
REQ-021 Throughput SHALL be at most one operation (write or clear) per two cycles.
REQ-022 wdata[sel] SHALL be used as sampled at the GRANT closing edge; requesters hold wdata until gnt is seen.
REQ-023 A req deasserted before arbitration SHALL be ignored; a req deasserted during GRANT SHALL NOT cancel the write.
REQ-024 gnt and clr_done SHALL never be high in the same cycle; gnt SHALL be 0 in IDLE and CLEAR.
REQ-025 clr_req asserted during GRANT SHALL be serviced only from the following IDLE; the write completes first.

Reset
REQ-026 With rst=1 at a posedge, the block SHALL set state=IDLE, ptr=0, sel=0, q=0, owner=0, regardless of state.
REQ-027 After that edge gnt, clr_done and busy SHALL all be 0; rst during GRANT or CLEAR SHALL abort the operation without updating q.
REQ-028 rst SHALL take priority over clr_req and req in the same cycle.

Structure
REQ-029 The state encoding (IDLE=0, GRANT=1, CLEAR=2) and default N/W SHALL live in the shared package.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs winner index, any).
REQ-031 q SHALL be a plain W-bit register bank with synchronous clear, the only storage of shared data.

Verification
REQ-032 rst=1 two cycles, then req=0 -> q=0, owner=0, gnt=0, busy=0.
REQ-033 req=4'b0010, wdata[1]=8'hA5 -> gnt=4'b0010 one cycle later for one cycle; q=8'hA5, owner=1 the next cycle.
REQ-034 req=4'b1111 held, distinct data, ptr=0 -> grants in order 0,1,2,3,0, one every two cycles.
REQ-035 q=8'h3C, then clr_req=1 together with req=4'b0001 -> clr_done pulse, q=8'h00, then gnt=4'b0001.
REQ-036 rst=1 asserted during a GRANT cycle for req[2] with wdata[2]=8'hFF -> q stays 8'h00, owner=0, ptr=0.
REQ-037 req=4'b1000 with ptr=3 after grant to 2, then req=4'b1001 -> grant 3, then wrap to grant 0.
